// File: rtl/riscv_mem_pkg.sv
// Memory-stage request codes, data-cache FSM states and the byte-lane
// helpers shared by the core decode and the data cache.
package riscv_mem_pkg;

    localparam logic [2:0] LOAD_LW  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LB  = 3'b010;
    localparam logic [2:0] LOAD_LHU = 3'b011;
    localparam logic [2:0] LOAD_LBU = 3'b100;

    localparam logic [1:0] STORE_SW = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SB = 2'b10;

    typedef enum logic [1:0] {
        DC_IDLE   = 2'b00,
        DC_REFILL = 2'b01,
        DC_WRITE  = 2'b10
    } dcache_state_t;

    // Unknown load codes fall back to a full word.
    function automatic logic [31:0] load_extend(input logic [2:0]  load_code,
                                                input logic [1:0]  byte_off,
                                                input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] result;
        byte_v = word[{byte_off, 3'b000} +: 8];
        half_v = byte_off[1] ? word[31:16] : word[15:0];
        case (load_code)
            LOAD_LH:  result = {{16{half_v[15]}}, half_v};
            LOAD_LB:  result = {{24{byte_v[7]}}, byte_v};
            LOAD_LHU: result = {16'h0000, half_v};
            LOAD_LBU: result = {24'h000000, byte_v};
            default:  result = word;
        endcase
        return result;
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] store_code,
                                              input logic [1:0] byte_off);
        logic [3:0] result;
        case (store_code)
            STORE_SB: result = 4'b0001 << byte_off;
            STORE_SH: result = byte_off[1] ? 4'b1100 : 4'b0011;
            default:  result = 4'b1111;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0]  store_code,
                                               input logic [31:0] wdata);
        logic [31:0] result;
        case (store_code)
            STORE_SB: result = {4{wdata[7:0]}};
            STORE_SH: result = {2{wdata[15:0]}};
            default:  result = wdata;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag and data storage for the direct-mapped data cache: one synchronous
// byte-enabled write port, one asynchronous read port. Not reset.
module dcache_array #(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 24,
    parameter int IDX_W          = $clog2(NUM_LINES),
    parameter int OFF_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [OFF_W-1:0] wr_word,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [OFF_W-1:0] rd_word,
    output logic [31:0]      rd_data,
    output logic [TAG_W-1:0] rd_tag
);

    logic [31:0]      data_mem [NUM_LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0] tag_mem  [NUM_LINES];

    // Byte-enabled data write: full word on refill, enabled lanes on store.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                data_mem[{wr_index, wr_word}][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Tag is written once, together with the last refill word.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    assign rd_data = data_mem[{rd_index, rd_word}];
    assign rd_tag  = tag_mem[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with a
// single-outstanding req/ack word interface towards main memory.
module dcache_controller
    import riscv_mem_pkg::*;
#(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  load,
    input  logic [1:0]  store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    dcache_state_t    state_r, state_nxt_s;
    logic [OFF_W-1:0] cnt_r;
    logic [NUM_LINES-1:0] valid_r;

    logic             mem_req_r, mem_we_r;
    logic [31:0]      mem_addr_r, mem_wdata_r;
    logic [3:0]       mem_wstrb_r;

    logic [TAG_W-1:0] tag_s, rd_tag_s;
    logic [IDX_W-1:0] index_s;
    logic [OFF_W-1:0] word_s, cnt_nxt_s;
    logic [31:0]      rd_data_s;
    logic             hit_s, ack_s, last_s, stall_s;

    logic [OFF_W-1:0] wr_word_s;
    logic [3:0]       wr_be_s;
    logic [31:0]      wr_data_s;
    logic             tag_we_s;

    assign tag_s     = addr[31 -: TAG_W];
    assign index_s   = addr[2+OFF_W +: IDX_W];
    assign word_s    = addr[2 +: OFF_W];
    assign hit_s     = valid_r[index_s] && (rd_tag_s == tag_s);
    assign ack_s     = mem_ack && mem_req_r;
    assign last_s    = (cnt_r == OFF_W'(WORDS_PER_LINE - 1));
    assign cnt_nxt_s = cnt_r + OFF_W'(1);

    dcache_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_array (
        .clk      (clk),
        .wr_index (index_s),
        .wr_word  (wr_word_s),
        .wr_be    (wr_be_s),
        .wr_data  (wr_data_s),
        .tag_we   (tag_we_s),
        .wr_tag   (tag_s),
        .rd_index (index_s),
        .rd_word  (word_s),
        .rd_data  (rd_data_s),
        .rd_tag   (rd_tag_s)
    );

    // Array write port: refill words on each ack, store merge on a hit ack.
    always_comb begin
        wr_word_s = word_s;
        wr_be_s   = 4'b0000;
        wr_data_s = mem_wdata_r;
        tag_we_s  = 1'b0;
        case (state_r)
            DC_REFILL: begin
                wr_word_s = cnt_r;
                wr_data_s = mem_rdata;
                if (ack_s) begin
                    wr_be_s  = 4'b1111;
                    tag_we_s = last_s;
                end else begin
                    wr_be_s  = 4'b0000;
                    tag_we_s = 1'b0;
                end
            end
            DC_WRITE: begin
                if (ack_s && hit_s) begin
                    wr_be_s = mem_wstrb_r;
                end else begin
                    wr_be_s = 4'b0000;
                end
            end
            default: begin
                wr_be_s = 4'b0000;
            end
        endcase
    end

    // Next-state decode; stores take priority over loads.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            DC_IDLE: begin
                if (mem_write) begin
                    state_nxt_s = DC_WRITE;
                end else if (mem_read && !hit_s) begin
                    state_nxt_s = DC_REFILL;
                end else begin
                    state_nxt_s = DC_IDLE;
                end
            end
            DC_REFILL: begin
                if (ack_s && last_s) begin
                    state_nxt_s = DC_IDLE;
                end else begin
                    state_nxt_s = DC_REFILL;
                end
            end
            DC_WRITE: begin
                if (ack_s) begin
                    state_nxt_s = DC_IDLE;
                end else begin
                    state_nxt_s = DC_WRITE;
                end
            end
            default: begin
                state_nxt_s = DC_IDLE;
            end
        endcase
    end

    // Stall and load data towards the core; stall drops in the store ack cycle.
    always_comb begin
        stall_s = 1'b0;
        rdata   = 32'h0000_0000;
        case (state_r)
            DC_IDLE:   stall_s = mem_write || (mem_read && !hit_s);
            DC_REFILL: stall_s = 1'b1;
            DC_WRITE:  stall_s = !ack_s;
            default:   stall_s = 1'b0;
        endcase
        if ((state_r == DC_IDLE) && mem_read && !stall_s) begin
            rdata = load_extend(load, addr[1:0], rd_data_s);
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    assign stall = stall_s;

    // FSM state and refill word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= DC_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == DC_IDLE) begin
                cnt_r <= '0;
            end else if ((state_r == DC_REFILL) && ack_s) begin
                cnt_r <= cnt_nxt_s;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Valid bits: a line becomes valid only after its last refill word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
        end else if ((state_r == DC_REFILL) && ack_s && last_s) begin
            valid_r[index_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Registered memory request, launched on entry to REFILL/WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_wstrb_r <= 4'b0000;
        end else begin
            case (state_r)
                DC_IDLE: begin
                    if (mem_write) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= {addr[31:2], 2'b00};
                        mem_wdata_r <= store_data(store, wdata);
                        mem_wstrb_r <= store_strb(store, addr[1:0]);
                    end else if (mem_read && !hit_s) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= {addr[31:2+OFF_W], {OFF_W{1'b0}}, 2'b00};
                        mem_wdata_r <= 32'h0000_0000;
                        mem_wstrb_r <= 4'b0000;
                    end else begin
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_wstrb_r <= 4'b0000;
                    end
                end
                DC_REFILL: begin
                    if (ack_s && last_s) begin
                        mem_req_r <= 1'b0;
                    end else if (ack_s) begin
                        mem_addr_r <= {addr[31:2+OFF_W], cnt_nxt_s, 2'b00};
                    end else begin
                        mem_req_r <= mem_req_r;
                    end
                end
                DC_WRITE: begin
                    if (ack_s) begin
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_wstrb_r <= 4'b0000;
                    end else begin
                        mem_req_r <= mem_req_r;
                    end
                end
                default: begin
                    mem_req_r   <= 1'b0;
                    mem_we_r    <= 1'b0;
                    mem_wstrb_r <= 4'b0000;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: expected memory transactions and
// load results are queued at stimulus time and checked when the DUT responds.
module tb_dcache_controller;

    localparam int          NUM_LINES = 64;
    localparam int          ACK_WAIT  = 2;
    localparam int          TIMEOUT   = 200;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  load = 3'b000;
    logic [1:0]  store = 2'b00;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [31:0] rdata;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;
    int ack_count = 0;
    int wait_cnt = 0;
    bit stray_ack = 1'b0;

    txn_t        txn_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] mem_model [logic [31:0]];

    dcache_controller #(.NUM_LINES(NUM_LINES), .WORDS_PER_LINE(4)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .load(load), .store(store), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic push_refill(input logic [31:0] line_addr);
        txn_t t;
        for (int w = 0; w < 4; w++) begin
            t.addr = line_addr + 32'(w * 4); t.we = 1'b0; t.wstrb = 4'b0000; t.wdata = 32'h0;
            txn_q.push_back(t);
        end
    endtask

    // Memory responder: acks each request after ACK_WAIT idle cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mem_ack = 1'b0; wait_cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0; wait_cnt = 0;
            end else if (stray_ack && !mem_req) begin
                mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; stray_ack = 1'b0;
            end else if (mem_req) begin
                wait_cnt++;
                if (wait_cnt > ACK_WAIT) begin
                    txn_t t;
                    if (txn_q.size() == 0) begin
                        check("unexpected_req", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        t = txn_q.pop_front();
                        check("req_addr", mem_addr, t.addr);
                        check("req_we", {31'h0, mem_we}, {31'h0, t.we});
                        check("req_wstrb", {28'h0, mem_wstrb}, {28'h0, t.wstrb});
                        if (t.we) check("req_wdata", mem_wdata, t.wdata);
                    end
                    mem_rdata = model_read(mem_addr);
                    mem_ack = 1'b1;
                    ack_count++;
                end
            end
        end
    end

    task automatic do_load(input logic [2:0] code, input logic [31:0] a,
                           input logic [31:0] exp, input bit exp_miss);
        int  stall_cycles = 0;
        bit  done = 1'b0;
        logic [31:0] e;
        if (exp_miss) push_refill({a[31:4], 4'h0});
        rd_q.push_back(exp);
        @(negedge clk);
        mem_read = 1'b1; load = code; addr = a;
        for (int i = 0; i < TIMEOUT && !done; i++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                e = rd_q.pop_front();
                check("load_rdata", rdata, e);
                check("load_miss", {31'h0, stall_cycles != 0}, {31'h0, exp_miss});
                check("refill_words_left", 32'(txn_q.size()), 32'd0);
            end else begin
                check("load_rdata_during_stall", rdata, 32'h0);
                stall_cycles++;
                @(negedge clk);
            end
        end
        if (!done) check("load_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
    endtask

    task automatic do_store(input logic [1:0] code, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        txn_t t;
        bit   done = 1'b0;
        logic [31:0] old;
        t.addr = exp_addr; t.we = 1'b1; t.wstrb = exp_strb; t.wdata = exp_wdata;
        txn_q.push_back(t);
        old = model_read(exp_addr);
        for (int b = 0; b < 4; b++)
            if (exp_strb[b]) old[b*8 +: 8] = exp_wdata[b*8 +: 8];
        mem_model[exp_addr] = old;
        @(negedge clk);
        mem_write = 1'b1; store = code; addr = a; wdata = d;
        for (int i = 0; i < TIMEOUT && !done; i++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                check("store_done", 32'(txn_q.size()), 32'd0);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("store_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    initial begin
        int base;
        bit got;
        mem_model[32'h40] = 32'h1111_1111;
        mem_model[32'h44] = 32'h2222_2222;
        mem_model[32'h48] = 32'h3333_3333;
        mem_model[32'h4C] = 32'h4444_4444;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Stray ack while idle must be ignored.
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_ack_req", {31'h0, mem_req}, 32'h0);
        check("stray_ack_stall", {31'h0, stall}, 32'h0);

        do_load(LOAD_LW_C(), 32'h40, 32'h1111_1111, 1'b1);
        do_load(3'b000, 32'h4C, 32'h4444_4444, 1'b0);

        do_store(2'b00, 32'h44, 32'h80FF_7F01, 32'h44, 4'b1111, 32'h80FF_7F01);
        do_load(3'b010, 32'h47, 32'hFFFF_FF80, 1'b0);
        do_load(3'b100, 32'h47, 32'h0000_0080, 1'b0);
        do_load(3'b001, 32'h46, 32'hFFFF_80FF, 1'b0);
        do_load(3'b011, 32'h44, 32'h0000_7F01, 1'b0);
        do_load(3'b111, 32'h46, 32'h80FF_7F01, 1'b0);

        do_store(2'b10, 32'h45, 32'h0000_00AB, 32'h44, 4'b0010, 32'hABAB_ABAB);
        do_load(3'b000, 32'h44, 32'h80FF_AB01, 1'b0);

        do_store(2'b01, 32'h1002, 32'h0000_BEEF, 32'h1000, 4'b1100, 32'hBEEF_BEEF);
        do_load(3'b000, 32'h1000, model_read(32'h1000), 1'b1);
        do_store(2'b11, 32'h48, 32'h1234_5678, 32'h48, 4'b1111, 32'h1234_5678);
        do_load(3'b000, 32'h48, 32'h1234_5678, 1'b0);

        do_load(3'b000, 32'h40, 32'h1111_1111, 1'b0);
        do_load(3'b000, 32'h40 + NUM_LINES * 16, model_read(32'h40 + NUM_LINES * 16), 1'b1);
        do_load(3'b000, 32'h40, 32'h1111_1111, 1'b1);

        // Reset after two of four refill acks.
        base = ack_count;
        push_refill(32'h840);
        @(negedge clk);
        mem_read = 1'b1; load = 3'b000; addr = 32'h840;
        got = 1'b0;
        for (int i = 0; i < TIMEOUT && !got; i++) begin
            @(posedge clk);
            #2;
            if (ack_count >= base + 2 && !mem_ack) got = 1'b1;
        end
        if (!got) check("reset_refill_timeout", 32'd1, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_refill_req", {31'h0, mem_req}, 32'h0);
        mem_read = 1'b0;
        txn_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_load(3'b000, 32'h40, 32'h1111_1111, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [2:0] LOAD_LW_C();
        return 3'b000;
    endfunction

endmodule
